// File: rtl/shift_unit_pipe_if.sv
// Request/result bundle for the pipelined shift/rotate unit.
// The requester drives the master side; the shift unit is the slave.
interface shift_unit_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int SHW = $clog2(XLEN);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       in_op_i;
  logic [XLEN-1:0]  in_data_i;
  logic [SHW-1:0]   in_shamt_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  out_data_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             out_err_o;

  modport master (
    output in_valid_i, in_op_i, in_data_i, in_shamt_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o, out_err_o
  );

  modport slave (
    input  in_valid_i, in_op_i, in_data_i, in_shamt_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o, out_err_o
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined XLEN-wide logarithmic shifter (SLL/SRL/SRA/ROL/ROR) with an elastic
// valid/ready pipeline, passthrough tag and synchronous flush.
module shift_unit_pipe #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  shift_unit_pipe_if.slave bus
);
  localparam int SHW   = $clog2(XLEN);
  localparam int BASE  = SHW / NUM_STAGES;
  localparam int EXTRA = SHW % NUM_STAGES;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  // One mux layer: shift/rotate by a fixed power of two. SRA fills from the
  // operand's original sign bit, which travels down the pipe alongside the data.
  function automatic logic [XLEN-1:0] shiftLayer(input logic [XLEN-1:0] x,
                                                 input logic [2:0] op,
                                                 input logic sign,
                                                 input int amt);
    case (op)
      OP_SLL:  return x << amt;
      OP_SRL:  return x >> amt;
      OP_SRA:  return (x >> amt) | (sign ? ~({XLEN{1'b1}} >> amt) : '0);
      OP_ROL:  return (x << amt) | (x >> (XLEN - amt));
      OP_ROR:  return (x >> amt) | (x << (XLEN - amt));
      default: return '0;
    endcase
  endfunction

  logic [NUM_STAGES-1:0] r_valid;
  logic [XLEN-1:0]       r_data  [NUM_STAGES];
  logic [2:0]            r_op    [NUM_STAGES];
  logic [SHW-1:0]        r_shamt [NUM_STAGES];
  logic                  r_sign  [NUM_STAGES];
  logic [TAG_W-1:0]      r_tag   [NUM_STAGES];
  logic                  r_err   [NUM_STAGES];

  logic [NUM_STAGES-1:0] w_srcValid;
  logic [XLEN-1:0]       w_srcData  [NUM_STAGES];
  logic [2:0]            w_srcOp    [NUM_STAGES];
  logic [SHW-1:0]        w_srcShamt [NUM_STAGES];
  logic                  w_srcSign  [NUM_STAGES];
  logic [TAG_W-1:0]      w_srcTag   [NUM_STAGES];
  logic                  w_srcErr   [NUM_STAGES];
  logic [XLEN-1:0]       w_nxtData  [NUM_STAGES];

  logic [NUM_STAGES-1:0] w_adv;
  logic [NUM_STAGES-1:0] w_load;
  logic                  w_inErr;
  logic [XLEN-1:0]       w_inData;

  // Reserved encodings zero the operand up front, so every layer yields zero.
  assign w_inErr  = bus.in_op_i > 3'd4;
  assign w_inData = w_inErr ? '0 : bus.in_data_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO  = k * BASE + ((k < EXTRA) ? k : EXTRA);
    localparam int CNT = BASE + ((k < EXTRA) ? 1 : 0);

    logic [XLEN-1:0] w_x;

    if (k == 0) begin : g_src_in
      assign w_srcValid[k] = bus.in_valid_i;
      assign w_srcData[k]  = w_inData;
      assign w_srcOp[k]    = bus.in_op_i;
      assign w_srcShamt[k] = bus.in_shamt_i;
      assign w_srcSign[k]  = w_inData[XLEN-1];
      assign w_srcTag[k]   = bus.in_tag_i;
      assign w_srcErr[k]   = w_inErr;
    end else begin : g_src_prev
      assign w_srcValid[k] = r_valid[k-1];
      assign w_srcData[k]  = r_data[k-1];
      assign w_srcOp[k]    = r_op[k-1];
      assign w_srcShamt[k] = r_shamt[k-1];
      assign w_srcSign[k]  = r_sign[k-1];
      assign w_srcTag[k]   = r_tag[k-1];
      assign w_srcErr[k]   = r_err[k-1];
    end

    always_comb begin
      w_x = w_srcData[k];
      for (int j = 0; j < CNT; j++) begin
        if (w_srcShamt[k][SHW'(LO + j)]) begin
          w_x = shiftLayer(w_x, w_srcOp[k], w_srcSign[k], 1 << (LO + j));
        end
      end
    end

    assign w_nxtData[k] = w_x;
  end

  // A stage moves on when the consumer takes the result or any later stage
  // holds a bubble; written flat so there is no combinational chain on w_adv.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_adv[k] = r_valid[k] & bus.out_ready_i;
      for (int j = k + 1; j < NUM_STAGES; j++) begin
        if (!r_valid[j]) w_adv[k] = r_valid[k];
      end
    end
  end

  assign w_load         = ~r_valid | w_adv;
  assign bus.in_ready_o = w_load[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_data[k]  <= '0;
        r_op[k]    <= '0;
        r_shamt[k] <= '0;
        r_sign[k]  <= 1'b0;
        r_tag[k]   <= '0;
        r_err[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (flush_i) begin
          r_valid[k] <= 1'b0;
        end else if (w_load[k]) begin
          r_valid[k] <= w_srcValid[k];
        end
        if (w_load[k]) begin
          r_data[k]  <= w_nxtData[k];
          r_op[k]    <= w_srcOp[k];
          r_shamt[k] <= w_srcShamt[k];
          r_sign[k]  <= w_srcSign[k];
          r_tag[k]   <= w_srcTag[k];
          r_err[k]   <= w_srcErr[k];
        end
      end
    end
  end

  assign bus.out_valid_o = r_valid[NUM_STAGES-1];
  assign bus.out_data_o  = r_data[NUM_STAGES-1];
  assign bus.out_tag_o   = r_tag[NUM_STAGES-1];
  assign bus.out_err_o   = r_err[NUM_STAGES-1];
endmodule
